// File: rtl/phase_seq_if.sv
// Handshake bundle between the phase sequencer and its run/step controller and decoders.
// master = sequencer side, slave = controller/decoder side.
interface phase_seq_if #(
    parameter int NPHASES = 6
);
    logic               run;
    logic               step;
    logic               done;
    logic [NPHASES-1:0] ck;
    logic [NPHASES-1:0] stb;
    logic               inst_start;
    logic               busy;
    logic               seq_err;

    modport master (
        input  run, step, done,
        output ck, stb, inst_start, busy, seq_err
    );

    modport slave (
        output run, step, done,
        input  ck, stb, inst_start, busy, seq_err
    );
endinterface

// File: rtl/phase_sequencer.sv
// Major-state timing generator: one-hot ck1,stb1,...,ckN,stbN slots with run/step/halt control.
// Optional feature: define SINGLE_STEP_EN to let a step pulse in IDLE execute one instruction.
module phase_sequencer #(
    parameter int NPHASES     = 6,
    parameter int SLOT_CYCLES = 1
) (
    input  logic          clk,
    input  logic          reset,
    phase_seq_if.master   seq
);
    localparam int PW = (NPHASES > 1) ? $clog2(NPHASES) : 1;
    localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [PW-1:0] LAST_PHASE = PW'(NPHASES - 1);
    localparam logic [CW-1:0] LAST_CNT   = CW'(SLOT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CK,
        S_STB
    } state_e;

    state_e             state_q, state_d;
    logic [PW-1:0]      phase_q, phase_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               halt_q, halt_d;
    logic               start_q, start_d;
    logic               busy_q, busy_d;
    logic [NPHASES-1:0] ck_q, ck_d;
    logic [NPHASES-1:0] stb_q, stb_d;
    logic               step_go;
    logic               slot_end;

`ifdef SINGLE_STEP_EN
    assign step_go = seq.step;
`else
    logic unused_step;
    assign unused_step = seq.step;
    assign step_go     = 1'b0;
`endif

    assign slot_end = (cnt_q == LAST_CNT);

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q + 1'b1;
        err_d   = err_q;
        halt_d  = halt_q | ~seq.run;
        start_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                halt_d = 1'b0;
                if (!err_q && (seq.run || step_go)) begin
                    state_d = S_CK;
                    phase_d = '0;
                    start_d = 1'b1;
                    halt_d  = ~seq.run;
                end
            end
            S_CK: begin
                if (slot_end) begin
                    cnt_d = '0;
                    if (seq.done) begin
                        // A halt latched anywhere in this instruction wins over a current run=1.
                        if (seq.run && !halt_q) begin
                            phase_d = '0;
                            start_d = 1'b1;
                            halt_d  = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                            phase_d = '0;
                        end
                    end else begin
                        state_d = S_STB;
                    end
                end
            end
            S_STB: begin
                if (slot_end) begin
                    cnt_d = '0;
                    if (phase_q == LAST_PHASE) begin
                        state_d = S_IDLE;
                        phase_d = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_CK;
                        phase_d = phase_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                phase_d = '0;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        ck_d   = (state_d == S_CK)  ? (NPHASES'(1) << phase_d) : '0;
        stb_d  = (state_d == S_STB) ? (NPHASES'(1) << phase_d) : '0;
    end

    // NOTE: state registers use non-blocking assignment so all flops update together on the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            halt_q  <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            ck_q    <= '0;
            stb_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            halt_q  <= halt_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            ck_q    <= ck_d;
            stb_q   <= stb_d;
        end
    end

    assign seq.ck         = ck_q;
    assign seq.stb        = stb_q;
    assign seq.inst_start = start_q;
    assign seq.busy       = busy_q;
    assign seq.seq_err    = err_q;
endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer: an instruction-level model expands each planned
// instruction into its slot list; a monitor compares every cycle's outputs against the queue.
module tb_phase_sequencer;
    localparam int NP = 4;
    localparam int SC = 2;
`ifdef SINGLE_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    typedef struct packed {
        logic [NP-1:0] ck;
        logic [NP-1:0] stb;
        logic          start;
        logic          busy;
        logic          err;
    } obs_t;

    typedef struct {
        bit   rst;
        bit   run;
        bit   step;
        bit   done;
        obs_t exp;
    } cyc_t;

    logic clk = 1'b0;
    logic reset;

    phase_seq_if #(.NPHASES(NP)) bus ();

    phase_sequencer #(.NPHASES(NP), .SLOT_CYCLES(SC)) dut (
        .clk   (clk),
        .reset (reset),
        .seq   (bus.master)
    );

    always #5 clk = ~clk;

    cyc_t plan[$];
    obs_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc_no = 0;
    bit   err_m = 1'b0;

    function automatic obs_t idle_obs();
        obs_t o = '0;
        o.err = err_m;
        return o;
    endfunction

    // Slot s: even = ck(s/2+1), odd = stb(s/2+1).
    function automatic obs_t slot_obs(int s, bit start);
        obs_t o = '0;
        o.busy  = 1'b1;
        o.start = start;
        o.err   = err_m;
        if (s % 2 == 0) o.ck[s/2]  = 1'b1;
        else            o.stb[s/2] = 1'b1;
        return o;
    endfunction

    // d = phase whose ck slot raises done (1..NP); 0 = never finishes.
    function automatic int nslots(int d);
        return (d == 0) ? 2 * NP : 2 * d - 1;
    endfunction

    function automatic int pick_d();
        int r = $urandom_range(0, 9);
        return (r == 0) ? 0 : 1 + (r % NP);
    endfunction

    task automatic add(bit rs, bit run, bit step, bit done, obs_t e);
        cyc_t c;
        c.rst = rs; c.run = run; c.step = step; c.done = done; c.exp = e;
        plan.push_back(c);
    endtask

    task automatic gap(int n);
        for (int k = 0; k < n; k++) add(1'b0, 1'b0, 1'b0, 1'(($urandom % 2)), idle_obs());
    endtask

    task automatic do_reset(int n);
        err_m = 1'b0;
        for (int k = 0; k < n; k++) add(1'b1, 1'(($urandom % 2)), 1'(($urandom % 2)), 1'b0, idle_obs());
    endtask

    // A burst of n_instr back-to-back instructions started by run (or by a step pulse).
    // The last run-started instruction drops run at a random point; abort_at >= 0 resets mid-instruction.
    task automatic burst(int n_instr, bit by_step, int abort_at, int force_d);
        bit run_lvl = !by_step;
        int d, d_next, len, drop;
        if (err_m || !(run_lvl || STEP_EN)) begin
            add(1'b0, run_lvl, by_step, 1'(($urandom % 2)), idle_obs());
            return;
        end
        d = (force_d >= 0) ? force_d : pick_d();
        d_next = d;
        add(1'b0, run_lvl, by_step, 1'(($urandom % 2)), slot_obs(0, 1'b1));
        for (int i = 0; i < n_instr; i++) begin
            len  = nslots(d) * SC;
            drop = (!by_step && i == n_instr - 1) ? $urandom_range(1, len) : len + 1;
            for (int j = 1; j <= len; j++) begin
                int s    = (j - 1) / SC;
                bit last = ((j - 1) % SC) == SC - 1;
                bit stp  = ($urandom % 4) == 0;
                bit dn;
                if (s % 2 == 0 && last) dn = (s / 2 == d - 1);
                else                    dn = 1'(($urandom % 2));
                if (j >= drop) run_lvl = 1'b0;
                if (i == 0 && j - 1 == abort_at) begin
                    err_m = 1'b0;
                    add(1'b1, run_lvl, stp, dn, idle_obs());
                    return;
                end
                if (j < len) begin
                    add(1'b0, run_lvl, stp, dn, slot_obs(j / SC, 1'b0));
                end else if (d == 0) begin
                    err_m = 1'b1;
                    add(1'b0, run_lvl, stp, dn, idle_obs());
                    return;
                end else if (run_lvl && i < n_instr - 1) begin
                    d_next = (force_d >= 0) ? force_d : pick_d();
                    add(1'b0, 1'b1, stp, dn, slot_obs(0, 1'b1));
                end else begin
                    add(1'b0, run_lvl, stp, dn, idle_obs());
                    return;
                end
            end
            d = d_next;
        end
    endtask

    // Monitor: one comparison per clock against the scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            obs_t e, o;
            e = sb.pop_front();
            o = {bus.ck, bus.stb, bus.inst_start, bus.busy, bus.seq_err};
            total++;
            cyc_no++;
            if (o !== e) begin
                bad++;
                $display("FAIL cycle%0d outputs: got ck=%b stb=%b start=%b busy=%b err=%b, want ck=%b stb=%b start=%b busy=%b err=%b",
                         cyc_no, o.ck, o.stb, o.start, o.busy, o.err,
                         e.ck, e.stb, e.start, e.busy, e.err);
            end
        end
    end

    initial begin
        reset    = 1'b1;
        bus.run  = 1'b0;
        bus.step = 1'b0;
        bus.done = 1'b0;

        do_reset(2);
        gap(5);
        burst(2, 1'b0, -1, 2);
        gap(2);
        burst(1, 1'b0, -1, 0);
        gap(2);
        burst(1, 1'b0, -1, 3);
        gap(1);
        burst(1, 1'b1, -1, 2);
        gap(2);
        do_reset(1);
        gap(1);
        burst(1, 1'b0, -1, 3);
        gap(1);
        burst(1, 1'b1, -1, 3);
        gap(1);
        burst(3, 1'b0, -1, 1);
        gap(1);
        burst(2, 1'b0, SC - 1, NP);
        gap(2);
        for (int it = 0; it < 60; it++) begin
            int kind = $urandom_range(0, 9);
            gap($urandom_range(1, 3));
            if (kind < 5)       burst($urandom_range(1, 4), 1'b0, -1, -1);
            else if (kind < 7)  burst(1, 1'b1, -1, -1);
            else if (kind < 8)  burst(2, 1'b0, $urandom_range(0, SC - 1), -1);
            else                do_reset($urandom_range(1, 2));
        end
        gap(2);

        foreach (plan[k]) begin
            reset    = plan[k].rst;
            bus.run  = plan[k].run;
            bus.step = plan[k].step;
            bus.done = plan[k].done;
            @(posedge clk);
            sb.push_back(plan[k].exp);
            #1;
        end
        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d unchecked entries, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
